// File: rtl/matmul_tile_flow_controller_pkg.sv
// Shared types for the matmul tile flow controller: instruction format,
// buffer/accumulator address types and the controller state encoding.
package matmul_tile_flow_controller_pkg;

  localparam int LENGTH_WIDTH           = 16;
  localparam int BUFFER_ADDR_WIDTH      = 16;
  localparam int ACCUMULATOR_ADDR_WIDTH = 8;

  typedef logic [BUFFER_ADDR_WIDTH-1:0]      buffer_addr_type;
  typedef logic [ACCUMULATOR_ADDR_WIDTH-1:0] accumulator_addr_type;

  // opcode[1] = accumulate, opcode[0] = signed operands
  typedef struct packed {
    logic [1:0]              opcode;
    logic [LENGTH_WIDTH-1:0] length;
    buffer_addr_type         buffer_addr;
    accumulator_addr_type    acc_addr;
  } instr_type;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_ISSUE,
    FC_WAIT_WEIGHT
  } matmul_fc_state_type;

endpackage

// File: rtl/matmul_tile_flow_controller_delay.sv
// Enable-gated shift-register delay line. Bit 0 of each word is its valid
// flag, so vld_any reports whether any stage still holds live data.
module tpu_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld_any
);

  logic [WIDTH-1:0] pipe_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_p[i] <= '0;
    end else if (enable) begin
      pipe_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

  always_comb begin
    vld_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) vld_any = vld_any | pipe_p[i][0];
  end

endmodule

// File: rtl/matmul_tile_flow_controller.sv
// Row issuer for matmul tiles: streams unified-buffer reads, then delays the
// row-tagged MMU and accumulator controls through two enable-gated pipelines.
module matmul_tile_flow_controller
  import matmul_tile_flow_controller_pkg::*;
#(
  parameter int MATRIX_WIDTH = 14,
  parameter int READ_LATENCY = 3,
  parameter int ACC_LATENCY  = MATRIX_WIDTH + 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  instr_type            instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 weight_ready,
  output buffer_addr_type      buffer_to_sds_addr,
  output logic                 buffer_read_enable,
  output logic                 mmu_sds_enable,
  output logic                 is_mmu_signed,
  output logic                 activate_weight,
  output accumulator_addr_type acc_addr,
  output logic                 accumulate,
  output logic                 acc_enable,
  output logic                 busy,
  output logic                 resource_busy
);

  localparam int PH_W  = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int SDS_W = 3;
  localparam int ACC_W = ACCUMULATOR_ADDR_WIDTH + 2;

  matmul_fc_state_type     state, state_d;
  logic [LENGTH_WIDTH-1:0] row_p0, row_d, len_p0;
  logic [PH_W-1:0]         phase_p0, phase_d;
  buffer_addr_type         base_buf_p0;
  accumulator_addr_type    base_acc_p0;
  logic                    accum_p0, sgn_p0;

  logic need_weight, can_issue, last_row, accept;
  logic [SDS_W-1:0] sds_din, sds_dout;
  logic [ACC_W-1:0] acc_din, acc_dout;
  logic sds_any, acc_any;

  // Stage 0: row issue. Every multiple of MATRIX_WIDTH starts a new weight tile.
  assign need_weight = (phase_p0 == '0);
  assign last_row    = (row_p0 == len_p0 - LENGTH_WIDTH'(1));
  assign can_issue   = ((state == FC_ISSUE) && (!need_weight || weight_ready)) ||
                       ((state == FC_WAIT_WEIGHT) && weight_ready);
  assign instr_ready = (state == FC_IDLE) || ((state == FC_ISSUE) && can_issue && last_row);
  assign accept      = instr_valid && instr_ready && enable;
  assign busy        = (state != FC_IDLE);

  always_comb begin
    state_d = state;
    row_d   = row_p0;
    phase_d = phase_p0;
    if (can_issue) begin
      if (last_row) begin
        state_d = FC_IDLE;
      end else begin
        state_d = FC_ISSUE;
        row_d   = row_p0 + LENGTH_WIDTH'(1);
        phase_d = (phase_p0 == PH_W'(MATRIX_WIDTH - 1)) ? '0 : phase_p0 + PH_W'(1);
      end
    end else if (state == FC_ISSUE) begin
      state_d = FC_WAIT_WEIGHT;
    end
    // A zero-length instruction is consumed without leaving IDLE.
    if (accept) begin
      state_d = (instr.length != '0) ? FC_ISSUE : FC_IDLE;
      row_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FC_IDLE;
      row_p0      <= '0;
      phase_p0    <= '0;
      len_p0      <= '0;
      base_buf_p0 <= '0;
      base_acc_p0 <= '0;
      accum_p0    <= 1'b0;
      sgn_p0      <= 1'b0;
    end else if (enable) begin
      state    <= state_d;
      row_p0   <= row_d;
      phase_p0 <= phase_d;
      if (accept) begin
        len_p0      <= instr.length;
        base_buf_p0 <= instr.buffer_addr;
        base_acc_p0 <= instr.acc_addr;
        accum_p0    <= instr.opcode[1];
        sgn_p0      <= instr.opcode[0];
      end
    end
  end

  assign buffer_read_enable = can_issue;
  assign buffer_to_sds_addr = can_issue ? buffer_addr_type'(base_buf_p0 + buffer_addr_type'(row_p0)) : '0;

  assign sds_din = can_issue ? {need_weight, sgn_p0, 1'b1} : '0;
  assign acc_din = can_issue ? {accumulator_addr_type'(base_acc_p0 + accumulator_addr_type'(row_p0)),
                                accum_p0, 1'b1} : '0;

  // Stage 1: row tags ride to the systolic data setup input.
  tpu_delay_line #(.WIDTH(SDS_W), .DEPTH(READ_LATENCY)) u_sds_delay (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .din     (sds_din),
    .dout    (sds_dout),
    .vld_any (sds_any)
  );

  // Stage 2: row tags ride on to the accumulator write port.
  tpu_delay_line #(.WIDTH(ACC_W), .DEPTH(READ_LATENCY + ACC_LATENCY)) u_acc_delay (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .din     (acc_din),
    .dout    (acc_dout),
    .vld_any (acc_any)
  );

  assign mmu_sds_enable  = sds_dout[0];
  assign is_mmu_signed   = sds_dout[1] & sds_dout[0];
  assign activate_weight = sds_dout[2] & sds_dout[0];
  assign acc_enable      = acc_dout[0];
  assign accumulate      = acc_dout[1] & acc_dout[0];
  assign acc_addr        = acc_dout[ACC_W-1:2];
  assign resource_busy   = busy | sds_any | acc_any;

endmodule

// File: tb/tb_matmul_tile_flow_controller.sv
// Scoreboard bench: stimulus pushes per-row expectations tagged with the
// enabled-cycle index at which each output stream must present them.
module tb_matmul_tile_flow_controller;
  import matmul_tile_flow_controller_pkg::*;

  localparam int MW = 4;
  localparam int RL = 3;
  localparam int AL = 9;

  logic clk = 1'b0;
  logic rst, enable, instr_valid, weight_ready;
  instr_type instr;
  logic instr_ready, buffer_read_enable, mmu_sds_enable, is_mmu_signed, activate_weight;
  logic accumulate, acc_enable, busy, resource_busy;
  buffer_addr_type buffer_to_sds_addr;
  accumulator_addr_type acc_addr;

  matmul_tile_flow_controller #(.MATRIX_WIDTH(MW), .READ_LATENCY(RL), .ACC_LATENCY(AL)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .instr              (instr),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .weight_ready       (weight_ready),
    .buffer_to_sds_addr (buffer_to_sds_addr),
    .buffer_read_enable (buffer_read_enable),
    .mmu_sds_enable     (mmu_sds_enable),
    .is_mmu_signed      (is_mmu_signed),
    .activate_weight    (activate_weight),
    .acc_addr           (acc_addr),
    .accumulate         (accumulate),
    .acc_enable         (acc_enable),
    .busy               (busy),
    .resource_busy      (resource_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [15:0] addr;
    logic        f1;
    logic        f2;
  } exp_t;

  exp_t rd_q[$];
  exp_t sds_q[$];
  exp_t acc_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ecyc = 0;
  int rcyc = 0;
  int wlo = 0;
  int whi = 0;
  int last_acc_rcyc = 0;
  logic prev_en_low = 1'b0;
  logic [32:0] prev_outs = '0;
  logic [32:0] outs;

  assign weight_ready = !((ecyc >= wlo) && (ecyc < whi));
  assign outs = {buffer_read_enable, buffer_to_sds_addr, mmu_sds_enable, is_mmu_signed,
                 activate_weight, acc_addr, accumulate, acc_enable, busy, resource_busy,
                 instr_ready};

  always @(posedge clk) begin
    rcyc <= rcyc + 1;
    if (!rst && enable) ecyc <= ecyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  function automatic instr_type mk(input logic [1:0] op, input int len,
                                   input logic [15:0] ba, input logic [7:0] aa);
    instr_type t;
    t.opcode      = op;
    t.length      = 16'(len);
    t.buffer_addr = ba;
    t.acc_addr    = aa;
    return t;
  endfunction

  // Row r issues at ka+1+r (plus any weight stall); SDS follows RL and the
  // accumulator RL+AL enabled cycles later.
  task automatic push_instr(input int ka, input logic [15:0] ba, input logic [7:0] aa,
                            input logic [1:0] op, input int len,
                            input int stall_row, input int stall_len);
    for (int r = 0; r < len; r++) begin
      int k;
      logic [7:0] a;
      exp_t e;
      k = ka + 1 + r + ((r >= stall_row) ? stall_len : 0);
      a = aa + 8'(r);
      e.k = k;           e.addr = ba + 16'(r); e.f1 = 1'b0;  e.f2 = 1'b0;               rd_q.push_back(e);
      e.k = k + RL;      e.addr = '0;          e.f1 = op[0]; e.f2 = ((r % MW) == 0);     sds_q.push_back(e);
      e.k = k + RL + AL; e.addr = {8'h00, a};  e.f1 = op[1]; e.f2 = 1'b0;               acc_q.push_back(e);
    end
  endtask

  task automatic send(input instr_type t, output int ka, output int ra);
    int g;
    g = 0;
    instr = t;
    instr_valid = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (!(instr_ready && enable) && g < 200);
    chk("accept_timeout", 64'(g >= 200), 64'(0));
    ka = ecyc;
    ra = rcyc;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((resource_busy || rd_q.size() != 0 || sds_q.size() != 0 || acc_q.size() != 0) && g < 300) begin
      @(negedge clk);
      #1 g++;
    end
    chk("drain_timeout", 64'(g >= 300), 64'(0));
    chk("drain_queues_empty", 64'(rd_q.size() + sds_q.size() + acc_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_en_low) chk("freeze_hold", 64'(outs), 64'(prev_outs));
      prev_en_low = !enable;
      prev_outs   = outs;
    end
    if (!rst && enable) begin
      if (buffer_read_enable) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(buffer_to_sds_addr), 64'hFFFF_FFFF);
        else begin
          e = rd_q.pop_front();
          chk("rd_addr", 64'(buffer_to_sds_addr), 64'(e.addr));
          chk("rd_cycle", 64'(ecyc), 64'(e.k));
        end
      end
      if (mmu_sds_enable) begin
        if (sds_q.size() == 0) chk("sds_unexpected", 64'(1), 64'(0));
        else begin
          e = sds_q.pop_front();
          chk("sds_signed", 64'(is_mmu_signed), 64'(e.f1));
          chk("sds_activate", 64'(activate_weight), 64'(e.f2));
          chk("sds_cycle", 64'(ecyc), 64'(e.k));
        end
      end else begin
        chk("sds_tags_gated", 64'({is_mmu_signed, activate_weight}), 64'(0));
      end
      if (acc_enable) begin
        last_acc_rcyc = rcyc;
        if (acc_q.size() == 0) chk("acc_unexpected", 64'(acc_addr), 64'hFFFF_FFFF);
        else begin
          e = acc_q.pop_front();
          chk("acc_addr", 64'(acc_addr), 64'(e.addr[7:0]));
          chk("acc_accumulate", 64'(accumulate), 64'(e.f1));
          chk("acc_cycle", 64'(ecyc), 64'(e.k));
        end
      end else begin
        chk("acc_accumulate_gated", 64'(accumulate), 64'(0));
      end
    end
  end

  initial begin
    int ka, ra, kb, rb;
    rst = 1'b1;
    enable = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    #2;
    chk("rst_instr_ready", 64'(instr_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resource_busy", 64'(resource_busy), 64'(0));
    chk("rst_read_enable", 64'(buffer_read_enable), 64'(0));
    chk("rst_sds_enable", 64'(mmu_sds_enable), 64'(0));
    chk("rst_acc_enable", 64'(acc_enable), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single instruction, two weight tiles, accumulate
    send(mk(2'b10, 6, 16'h0010, 8'h20), ka, ra);
    push_instr(ka, 16'h0010, 8'h20, 2'b10, 6, 99, 0);
    drain();

    // Back-to-back instructions with different signedness
    send(mk(2'b01, 4, 16'h0040, 8'h08), ka, ra);
    push_instr(ka, 16'h0040, 8'h08, 2'b01, 4, 99, 0);
    send(mk(2'b00, 4, 16'h0044, 8'h0C), kb, rb);
    chk("b2b_accept_cycle", 64'(kb), 64'(ka + 4));
    push_instr(ka + 4, 16'h0044, 8'h0C, 2'b00, 4, 99, 0);
    drain();

    // weight_ready low for 5 cycles exactly when row 4 wants its tile
    send(mk(2'b00, 8, 16'h0100, 8'h50), ka, ra);
    wlo = ka + 5;
    whi = ka + 10;
    push_instr(ka, 16'h0100, 8'h50, 2'b00, 8, 4, 5);
    drain();
    wlo = 0;
    whi = 0;

    // Three frozen cycles mid-stream
    send(mk(2'b11, 6, 16'h0080, 8'h30), ka, ra);
    push_instr(ka, 16'h0080, 8'h30, 2'b11, 6, 99, 0);
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    drain();
    chk("freeze_stretch", 64'(last_acc_rcyc), 64'(ra + 5 + 1 + RL + AL + 3));

    // Accumulator address wraps past its maximum
    send(mk(2'b11, 3, 16'h0200, 8'hFE), ka, ra);
    push_instr(ka, 16'h0200, 8'hFE, 2'b11, 3, 99, 0);
    drain();

    // Zero-length instruction is consumed without issuing rows
    send(mk(2'b10, 0, 16'h0222, 8'h11), ka, ra);
    @(negedge clk);
    chk("len0_busy", 64'(busy), 64'(0));
    chk("len0_read_enable", 64'(buffer_read_enable), 64'(0));
    drain();

    // Asynchronous reset mid-instruction, then a normal instruction
    send(mk(2'b10, 8, 16'h0300, 8'h60), ka, ra);
    push_instr(ka, 16'h0300, 8'h60, 2'b10, 8, 99, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_sds_enable", 64'(mmu_sds_enable), 64'(1));
    rst = 1'b1;
    rd_q.delete();
    sds_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_read_enable", 64'(buffer_read_enable), 64'(0));
    chk("midrst_read_addr", 64'(buffer_to_sds_addr), 64'(0));
    chk("midrst_sds_enable", 64'(mmu_sds_enable), 64'(0));
    chk("midrst_acc_enable", 64'(acc_enable), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_resource_busy", 64'(resource_busy), 64'(0));
    chk("midrst_instr_ready", 64'(instr_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(mk(2'b01, 2, 16'h0400, 8'h70), ka, ra);
    push_instr(ka, 16'h0400, 8'h70, 2'b01, 2, 99, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matmul_tile_flow_controller.md
MATMUL_TILE_FLOW_CONTROLLER -- requirements
Module: matmul_tile_flow_controller

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14, systolic array dimension and weight-tile height in rows.
REQ-002 SHALL have parameter READ_LATENCY, default 3, cycles from buffer read to MMU systolic data setup (SDS) input.
REQ-003 SHALL have parameter ACC_LATENCY, default MATRIX_WIDTH+5, cycles from SDS input to accumulator write.
REQ-004 SHALL have port clk, in, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, in, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable, in, 1, global advance; when low, all state, counters and pipelines freeze.
REQ-007 SHALL have port instr, in, instr_type, instruction carrying opcode, length, buffer_addr and acc_addr.
REQ-008 SHALL have port instr_valid, in, 1, instr is presented.
REQ-009 SHALL have port instr_ready, out, 1, instruction is accepted this cycle when instr_valid && instr_ready && enable.
REQ-010 SHALL have port weight_ready, in, 1, next weight tile is preloaded and may be activated.
REQ-011 SHALL have ports buffer_to_sds_addr (buffer_addr_type) and buffer_read_enable (1), both out, unified-buffer read request.
REQ-012 SHALL have ports mmu_sds_enable, is_mmu_signed and activate_weight, all out, 1 bit each, MMU controls.
REQ-013 SHALL have ports acc_addr (accumulator_addr_type), accumulate (1) and acc_enable (1), all out, accumulator write controls.
REQ-014 SHALL have ports busy and resource_busy, out, 1 bit each, status.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, WAIT_WEIGHT; busy = (state != IDLE).
REQ-016 instr_ready SHALL be high in IDLE, and in ISSUE only during the cycle the last row issues; otherwise low.
REQ-017 Accept SHALL latch base addresses, length, accumulate = opcode[1], signed = opcode[0]; clear the row counter; go to ISSUE.
REQ-018 Accept with length 0 SHALL be consumed with no row issued; state stays or returns to IDLE.
REQ-019 Each enabled ISSUE cycle SHALL issue row r: buffer_read_enable=1, buffer_to_sds_addr=base+r, acc address acc_base+r, with modulo-2^width wrap.
REQ-020 Row r with r mod MATRIX_WIDTH == 0 SHALL carry activate_weight; if weight_ready is low at that point, no row issues and FSM enters WAIT_WEIGHT.
REQ-021 WAIT_WEIGHT SHALL exit to ISSUE in the cycle weight_ready is high, issuing the pending row in that same cycle.
REQ-022 A new instruction accepted while the last row issues SHALL start its row 0 the next cycle with no bubble; the weight phase restarts at 0.
REQ-023 After the last row, with no accept, the FSM SHALL return to IDLE.
REQ-024 mmu_sds_enable, is_mmu_signed and activate_weight SHALL be row-tagged and appear READ_LATENCY enabled cycles after the row issues; is_mmu_signed and activate_weight SHALL be 0 whenever mmu_sds_enable=0.
REQ-025 acc_enable, accumulate and acc_addr SHALL appear READ_LATENCY+ACC_LATENCY enabled cycles after the row issues; accumulate SHALL be 0 whenever acc_enable=0.
REQ-026 Tags SHALL travel with each row so that overlapping instructions keep their own signed/accumulate values.
REQ-027 resource_busy SHALL equal busy OR any valid bit in either delay pipeline.

Reset
REQ-028 While rst is asserted, the block SHALL immediately clear the FSM to IDLE, clear all counters and pipelines, and drive every output 0 except instr_ready=1, regardless of enable or mid-operation state.

Structure
REQ-029 The shared package SHALL hold instr_type, buffer_addr_type, accumulator_addr_type and LENGTH_WIDTH (existing), plus a new enum matmul_fc_state_type.
REQ-030 The delays SHALL be built from one sub-module, tpu_delay_line (parameters WIDTH and DEPTH; enable; async reset), instantiated once per pipeline.

Verification (MATRIX_WIDTH=4, READ_LATENCY=3, ACC_LATENCY=9)
REQ-031 Single instr, length 6, buffer 0x10, acc 0x20, opcode 2'b10 -> reads 0x10..0x15 over 6 cycles; SDS 3 cycles later with activate_weight on rows 0 and 4; acc_enable 12 cycles after the reads, addresses 0x20..0x25, accumulate=1.
REQ-032 Two back-to-back instrs of length 4, opcodes 2'b01 then 2'b00 -> 8 contiguous reads; is_mmu_signed 1 for 4 cycles then 0.
REQ-033 weight_ready low for 5 cycles at row 4 -> exactly a 5-cycle gap in reads, SDS and accumulator streams.
REQ-034 enable low 3 cycles mid-stream -> all outputs hold; total sequence stretched by 3 cycles.
REQ-035 acc_addr = max-1, length 3 -> acc_addr sequence max-1, max, 0.
REQ-036 rst asserted mid-instruction -> outputs cleared immediately without a clock edge; resource_busy=0; a new instruction runs normally afterwards.
